// File: rtl/vram_scanout_arbiter_pkg.sv
// Shared types and defaults for the VRAM scanout arbiter.
//   owner_t   : who issued a VRAM read (display fetcher or GPU)
//   state_t   : line-fetch FSM states
//   ret_tag_t : tag carried alongside each outstanding VRAM read
//   next_row  : row that follows 'row' in a frame of rows_total rows
package scanout_pkg;

  localparam int unsigned V_ACTIVE_DEF   = 480;
  localparam int unsigned ROWS_TOTAL_DEF = 521;
  localparam int unsigned LB_IDX_W       = 9;
  localparam int unsigned FAIR_LIMIT     = 8;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_GPU  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                valid;
    owner_t              owner;
    logic                epoch;
    logic                bank;
    logic [LB_IDX_W-1:0] idx;
  } ret_tag_t;

  function automatic logic [9:0] next_row(input logic [9:0] row,
                                          input int unsigned rows_total);
    return (row == 10'(rows_total - 1)) ? '0 : row + 10'd1;
  endfunction

endpackage

// File: rtl/vram_scanout_arbiter_if.sv
// Bus bundle for the VRAM scanout arbiter: GPU request/response, the shared
// VRAM port and the line-buffer write port.
//   master : arbiter side (drives gnt/rvalid/rdata, vram_*, lb_*)
//   slave  : environment side (GPU, VRAM, line buffer)
interface vram_scanout_arbiter_if #(
  parameter int unsigned ADDR_W = 19
);
  import scanout_pkg::*;

  logic                gpu_req;
  logic                gpu_we;
  logic [ADDR_W-1:0]   gpu_addr;
  logic [15:0]         gpu_wdata;
  logic                gpu_gnt;
  logic                gpu_rvalid;
  logic [15:0]         gpu_rdata;

  logic                vram_req;
  logic                vram_ready;
  logic                vram_we;
  logic [ADDR_W-1:0]   vram_addr;
  logic [15:0]         vram_wdata;
  logic [15:0]         vram_rdata;

  logic                lb_we;
  logic                lb_bank;
  logic [LB_IDX_W-1:0] lb_addr;
  logic [15:0]         lb_wdata;

  modport master (
    input  gpu_req, gpu_we, gpu_addr, gpu_wdata, vram_ready, vram_rdata,
    output gpu_gnt, gpu_rvalid, gpu_rdata,
    output vram_req, vram_we, vram_addr, vram_wdata,
    output lb_we, lb_bank, lb_addr, lb_wdata
  );

  modport slave (
    output gpu_req, gpu_we, gpu_addr, gpu_wdata, vram_ready, vram_rdata,
    input  gpu_gnt, gpu_rvalid, gpu_rdata,
    input  vram_req, vram_we, vram_addr, vram_wdata,
    input  lb_we, lb_bank, lb_addr, lb_wdata
  );

endinterface

// File: rtl/vram_scanout_arbiter_return_pipe.sv
// vram_return_pipe: RD_LAT-deep shift register of read tags. The tail stage
// lines up with vram_rdata and is decoded into a line-buffer write (display
// read of the current epoch) or a GPU read response.
//   clk, rst   : clock, async active-high reset (clears all entries)
//   load, tag  : push a tag for a read accepted this cycle
//   cur_epoch  : current fetch epoch; display returns of other epochs are dropped
//   rdata      : VRAM read data
//   lb_*       : line-buffer write port
//   gpu_rvalid, gpu_rdata : GPU read response
//   disp_busy  : a display read will still be outstanding next cycle
module vram_return_pipe
  import scanout_pkg::*;
#(
  parameter int unsigned RD_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  ret_tag_t            tag,
  input  logic                cur_epoch,
  input  logic [15:0]         rdata,
  output logic                lb_we,
  output logic                lb_bank,
  output logic [LB_IDX_W-1:0] lb_addr,
  output logic [15:0]         lb_wdata,
  output logic                gpu_rvalid,
  output logic [15:0]         gpu_rdata,
  output logic                disp_busy
);

  ret_tag_t pipe [RD_LAT];
  ret_tag_t tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= load ? tag : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

  always_comb begin
    lb_we      = 1'b0;
    lb_bank    = 1'b0;
    lb_addr    = '0;
    lb_wdata   = '0;
    gpu_rvalid = 1'b0;
    gpu_rdata  = '0;
    if (tail.valid) begin
      if (tail.owner == OWN_GPU) begin
        gpu_rvalid = 1'b1;
        gpu_rdata  = rdata;
      end else if (tail.epoch == cur_epoch) begin
        lb_we    = 1'b1;
        lb_bank  = tail.bank;
        lb_addr  = tail.idx;
        lb_wdata = rdata;
      end
    end
  end

  // The tail stage returns this cycle, so only earlier stages keep a fetch busy.
  always_comb begin
    disp_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      if (pipe[i].valid && pipe[i].owner == OWN_DISP) disp_busy = 1'b1;
    end
  end

endmodule

// File: rtl/vram_scanout_arbiter.sv
// vram_scanout_arbiter: shares one VRAM port between the scanout line fetcher
// and the GPU. On each line_start the display bank flips and, for visible
// rows, the next (line-doubled) source line is prefetched into the idle bank
// of a ping-pong line buffer. GPU accesses use every slot the fetcher leaves.
//   CLOCK_50, reset : clock, async active-high reset
//   row, line_start : timing-generator row and row-start pulse
//   fb_base         : framebuffer origin, latched when a row-0 fetch starts
//   bus             : GPU, VRAM and line-buffer signals (master modport)
//   disp_bank       : bank the display reads
//   underrun        : line_start arrived before the previous fetch finished
// Optional: define SCANOUT_GPU_FAIRNESS_EN to force a GPU slot after 8
// consecutive display grants while the GPU is waiting.
module vram_scanout_arbiter
  import scanout_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned LINE_WORDS  = 320,
  parameter int unsigned LINE_STRIDE = 1024,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned ROWS_TOTAL  = ROWS_TOTAL_DEF,
  parameter int unsigned RD_LAT      = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [9:0]            row,
  input  logic                  line_start,
  input  logic [ADDR_W-1:0]     fb_base,
  vram_scanout_arbiter_if.master bus,
  output logic                  disp_bank,
  output logic                  underrun
);

  state_t              state;
  logic [LB_IDX_W-1:0] idx;
  logic                epoch;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   src_line;

  logic [9:0]          nxt;
  logic                start_fetch;
  logic                go_idle;
  logic                disp_pend;
  logic                fair_force;
  logic                sel_gpu;
  logic                sel_disp;
  logic                accept;
  logic                disp_acc;
  logic                load;
  logic                disp_busy;
  logic [ADDR_W-1:0]   fetch_addr;
  ret_tag_t            tag_in;

  always_comb begin
    nxt         = next_row(row, ROWS_TOTAL);
    start_fetch = (nxt < 10'(V_ACTIVE));
    fetch_addr  = base_q + src_line * ADDR_W'(LINE_STRIDE) + ADDR_W'(idx);
  end

  assign underrun = line_start && (state != S_IDLE);

  // The port stays quiet in any cycle the FSM is about to enter IDLE.
  always_comb begin
    go_idle = 1'b0;
    if (line_start)             go_idle = (state != S_IDLE) && !start_fetch;
    else if (state == S_DRAIN)  go_idle = !disp_busy;
  end

  always_comb begin
    disp_pend      = (state == S_FETCH);
    sel_gpu        = bus.gpu_req && (!disp_pend || fair_force);
    sel_disp       = disp_pend && !sel_gpu;
    bus.vram_req   = 1'b0;
    bus.vram_we    = 1'b0;
    bus.vram_addr  = '0;
    bus.vram_wdata = '0;
    bus.gpu_gnt    = 1'b0;
    if (!reset && !go_idle) begin
      if (sel_disp) begin
        bus.vram_req  = 1'b1;
        bus.vram_addr = fetch_addr;
      end else if (sel_gpu) begin
        bus.vram_req   = 1'b1;
        bus.vram_we    = bus.gpu_we;
        bus.vram_addr  = bus.gpu_addr;
        bus.vram_wdata = bus.gpu_wdata;
        bus.gpu_gnt    = bus.vram_ready;
      end
    end
    accept   = bus.vram_req && bus.vram_ready;
    disp_acc = accept && sel_disp;
    load     = accept && !bus.vram_we;
  end

  // disp_bank has already flipped for this row, so ~disp_bank is the bank the
  // display will read after the next flip.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = 1'b1;
    tag_in.owner = sel_disp ? OWN_DISP : OWN_GPU;
    tag_in.epoch = epoch;
    tag_in.bank  = ~disp_bank;
    tag_in.idx   = sel_disp ? idx : '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      epoch     <= 1'b0;
      disp_bank <= 1'b0;
      base_q    <= '0;
      src_line  <= '0;
    end else if (line_start) begin
      disp_bank <= ~disp_bank;
      // Restarting mid-fetch: new epoch so stale returns are discarded.
      if (state != S_IDLE) epoch <= ~epoch;
      if (start_fetch) begin
        state    <= S_FETCH;
        idx      <= '0;
        src_line <= ADDR_W'(nxt >> 1);
        if (nxt == '0) base_q <= fb_base;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (disp_acc) begin
            if (idx == LB_IDX_W'(LINE_WORDS - 1)) state <= S_DRAIN;
            idx <= idx + LB_IDX_W'(1);
          end
        end
        S_DRAIN: begin
          if (!disp_busy) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

`ifdef SCANOUT_GPU_FAIRNESS_EN
  logic [3:0] fair_cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fair_cnt <= '0;
    end else if (!bus.gpu_req || bus.gpu_gnt) begin
      fair_cnt <= '0;
    end else if (disp_acc && fair_cnt != 4'(FAIR_LIMIT)) begin
      fair_cnt <= fair_cnt + 4'd1;
    end
  end

  assign fair_force = (fair_cnt == 4'(FAIR_LIMIT));
`else
  assign fair_force = 1'b0;
`endif

  vram_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_ret (
    .clk        (CLOCK_50),
    .rst        (reset),
    .load       (load),
    .tag        (tag_in),
    .cur_epoch  (epoch),
    .rdata      (bus.vram_rdata),
    .lb_we      (bus.lb_we),
    .lb_bank    (bus.lb_bank),
    .lb_addr    (bus.lb_addr),
    .lb_wdata   (bus.lb_wdata),
    .gpu_rvalid (bus.gpu_rvalid),
    .gpu_rdata  (bus.gpu_rdata),
    .disp_busy  (disp_busy)
  );

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Self-checking bench for vram_scanout_arbiter: table of line_start vectors
// plus directed sequences for GPU arbitration, underrun and mid-fetch reset.
module tb_vram_scanout_arbiter;

  localparam int unsigned RD_LAT = 3;

  logic        clk;
  logic        rst;
  logic [9:0]  row;
  logic        line_start;
  logic [18:0] fb_base;
  logic        disp_bank;
  logic        underrun;

  vram_scanout_arbiter_if #(.ADDR_W(19)) bus ();

  vram_scanout_arbiter #(
    .ADDR_W      (19),
    .LINE_WORDS  (320),
    .LINE_STRIDE (1024),
    .V_ACTIVE    (480),
    .ROWS_TOTAL  (521),
    .RD_LAT      (RD_LAT)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .row        (row),
    .line_start (line_start),
    .fb_base    (fb_base),
    .bus        (bus),
    .disp_bank  (disp_bank),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [18:0] a);
    return a[15:0] ^ {13'b0, a[18:16]} ^ 16'hA5A5;
  endfunction

  // VRAM model: fixed-latency read returns.
  logic        vm_valid [RD_LAT];
  logic [15:0] vm_data  [RD_LAT];

  always @(posedge clk) begin
    vm_valid[0] <= bus.vram_req & bus.vram_ready & ~bus.vram_we;
    vm_data[0]  <= pat(bus.vram_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      vm_valid[i] <= vm_valid[i-1];
      vm_data[i]  <= vm_data[i-1];
    end
  end

  assign bus.vram_rdata = vm_valid[RD_LAT-1] ? vm_data[RD_LAT-1] : 16'hDEAD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observations since the last mon_reset.
  logic [18:0] m_first;
  logic        m_bank;
  int m_iss, m_addr_bad, m_first_iss, m_lb, m_lb_bad, m_first_lb, m_unr;
  int m_gnt, m_gnt_cyc, m_disp_wait, m_rv, m_rv_cyc;
  logic [15:0] m_rv_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_reset(input logic [18:0] first, input logic bank);
    m_first = first; m_bank = bank;
    m_iss = 0; m_addr_bad = 0; m_first_iss = -1; m_lb = 0; m_lb_bad = 0;
    m_first_lb = -1; m_unr = 0; m_gnt = 0; m_gnt_cyc = -1; m_disp_wait = 0;
    m_rv = 0; m_rv_cyc = -1; m_rv_data = '0;
  endtask

  task automatic mon();
    logic [18:0] ea;
    if (!rst) begin
      if (bus.vram_req && bus.vram_ready && !bus.gpu_gnt) begin
        if (m_iss == 0) m_first_iss = cyc;
        ea = m_first + 19'(m_iss);
        if (bus.vram_addr !== ea || bus.vram_we !== 1'b0) m_addr_bad++;
        if (bus.gpu_req && m_gnt == 0) m_disp_wait++;
        m_iss++;
      end
      if (bus.lb_we) begin
        if (m_lb == 0) m_first_lb = cyc;
        ea = m_first + 19'(m_lb);
        if (bus.lb_addr !== 9'(m_lb) || bus.lb_wdata !== pat(ea) || bus.lb_bank !== m_bank)
          m_lb_bad++;
        m_lb++;
      end
      if (bus.gpu_gnt) begin m_gnt++; m_gnt_cyc = cyc; end
      if (bus.gpu_rvalid) begin m_rv++; m_rv_cyc = cyc; m_rv_data = bus.gpu_rdata; end
      if (underrun) m_unr++;
    end
  endtask

  task automatic half(); @(negedge clk); mon(); endtask
  task automatic fin();  @(posedge clk); #1; cyc++; endtask
  task automatic step(); half(); fin(); endtask

  function automatic logic [63:0] bus_outs();
    return 64'({bus.gpu_gnt, bus.gpu_rvalid, bus.gpu_rdata, bus.vram_req,
                bus.vram_we, bus.vram_addr, bus.vram_wdata});
  endfunction

  function automatic logic [63:0] lb_outs();
    return 64'({bus.lb_we, bus.lb_bank, bus.lb_addr, bus.lb_wdata, disp_bank, underrun});
  endfunction

  typedef struct {
    logic [9:0]  row;
    logic [18:0] fb;
    logic        fetch;
    logic [18:0] first;
    logic        bank;
    logic        disp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_cyc;
    vecs[0] = '{10'd520, 19'h01000, 1'b1, 19'h01000, 1'b0, 1'b1};
    vecs[1] = '{10'd0,   19'h07000, 1'b1, 19'h01000, 1'b1, 1'b0};
    vecs[2] = '{10'd1,   19'h07000, 1'b1, 19'h01400, 1'b0, 1'b1};
    vecs[3] = '{10'd478, 19'h07000, 1'b1, 19'h3CC00, 1'b1, 1'b0};
    vecs[4] = '{10'd479, 19'h07000, 1'b0, 19'h00000, 1'b0, 1'b1};
    vecs[5] = '{10'd500, 19'h07000, 1'b0, 19'h00000, 1'b0, 1'b0};
    vecs[6] = '{10'd520, 19'h7FC00, 1'b1, 19'h7FC00, 1'b0, 1'b1};
    vecs[7] = '{10'd3,   19'h01000, 1'b1, 19'h00400, 1'b1, 1'b0};

    rst = 1'b1; row = '0; line_start = 1'b0; fb_base = '0;
    bus.gpu_req = 1'b0; bus.gpu_we = 1'b0; bus.gpu_addr = '0; bus.gpu_wdata = '0;
    bus.vram_ready = 1'b1;
    mon_reset('0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    half();
    check("reset_bus_outs", bus_outs(), 64'd0);
    check("reset_lb_outs", lb_outs(), 64'd0);
    fin();
    rst = 1'b0;
    step();
    check("post_reset_bus_outs", bus_outs(), 64'd0);
    check("post_reset_lb_outs", lb_outs(), 64'd0);

    // Line-start vectors: row decode, base latch, line doubling, wrap, banks.
    for (int i = 0; i < 8; i++) begin
      mon_reset(vecs[i].first, vecs[i].bank);
      row = vecs[i].row; fb_base = vecs[i].fb; line_start = 1'b1;
      ls_cyc = cyc;
      step();
      line_start = 1'b0;
      repeat (340) step();
      check($sformatf("v%0d_issues", i), 64'(m_iss), vecs[i].fetch ? 64'd320 : 64'd0);
      check($sformatf("v%0d_lb_writes", i), 64'(m_lb), vecs[i].fetch ? 64'd320 : 64'd0);
      check($sformatf("v%0d_disp_bank", i), 64'(disp_bank), 64'(vecs[i].disp));
      check($sformatf("v%0d_underruns", i), 64'(m_unr), 64'd0);
      if (vecs[i].fetch) begin
        check($sformatf("v%0d_addr_errs", i), 64'(m_addr_bad), 64'd0);
        check($sformatf("v%0d_lb_errs", i), 64'(m_lb_bad), 64'd0);
        check($sformatf("v%0d_first_issue_lat", i), 64'(m_first_iss - ls_cyc), 64'd1);
        check($sformatf("v%0d_first_lb_lat", i), 64'(m_first_lb - m_first_iss), 64'(RD_LAT));
      end
      check($sformatf("v%0d_idle_req", i), 64'(bus.vram_req), 64'd0);
    end

    // GPU read during a fetch.
    mon_reset(19'h01000, 1'b0);
    row = 10'd520; fb_base = 19'h01000; line_start = 1'b1;
    step();
    line_start = 1'b0;
    bus.gpu_req = 1'b1; bus.gpu_we = 1'b0; bus.gpu_addr = 19'h00055;
    for (int i = 0; i < 400 && m_gnt == 0; i++) step();
    bus.gpu_req = 1'b0;
    repeat (340) step();
    check("gpu_gnt_count", 64'(m_gnt), 64'd1);
`ifdef SCANOUT_GPU_FAIRNESS_EN
    check("gpu_disp_grants_before_gnt", 64'(m_disp_wait), 64'd8);
`else
    check("gpu_disp_grants_before_gnt", 64'(m_disp_wait), 64'd320);
`endif
    check("gpu_rvalid_count", 64'(m_rv), 64'd1);
    check("gpu_rvalid_lat", 64'(m_rv_cyc - m_gnt_cyc), 64'(RD_LAT));
    check("gpu_rdata", 64'(m_rv_data), 64'h0000_0000_0000_A5F0);
    check("gpu_fetch_issues", 64'(m_iss), 64'd320);
    check("gpu_fetch_addr_errs", 64'(m_addr_bad), 64'd0);
    check("gpu_fetch_lb_writes", 64'(m_lb), 64'd320);
    check("gpu_fetch_lb_errs", 64'(m_lb_bad), 64'd0);

    // GPU write while idle: granted at once, no read response.
    mon_reset('0, 1'b0);
    bus.gpu_req = 1'b1; bus.gpu_we = 1'b1; bus.gpu_addr = 19'h12345; bus.gpu_wdata = 16'hBEEF;
    half();
    check("gpu_wr_gnt", 64'(bus.gpu_gnt), 64'd1);
    check("gpu_wr_vram", 64'({bus.vram_req, bus.vram_we, bus.vram_addr, bus.vram_wdata}),
          64'({1'b1, 1'b1, 19'h12345, 16'hBEEF}));
    fin();
    bus.gpu_req = 1'b0; bus.gpu_we = 1'b0;
    repeat (6) step();
    check("gpu_wr_no_rvalid", 64'(m_rv), 64'd0);

    // Underrun: stalled fetch, reads in flight when the next line_start lands.
    mon_reset(19'h01000, 1'b1);
    bus.vram_ready = 1'b0;
    row = 10'd0; fb_base = 19'h05000; line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (1500) step();
    check("stall_req_held", 64'({bus.vram_req, bus.vram_addr}), 64'({1'b1, 19'h01000}));
    check("stall_no_issue", 64'(m_iss), 64'd0);
    bus.vram_ready = 1'b1;
    step();
    step();
    row = 10'd1; line_start = 1'b1;
    half();
    check("underrun_pulse", 64'(underrun), 64'd1);
    fin();
    line_start = 1'b0;
    mon_reset(19'h01400, 1'b0);
    step();
    check("underrun_single_cycle", 64'(m_unr), 64'd0);
    repeat (340) step();
    check("underrun_disp_bank", 64'(disp_bank), 64'd1);
    check("underrun_issues", 64'(m_iss), 64'd320);
    check("underrun_addr_errs", 64'(m_addr_bad), 64'd0);
    check("underrun_lb_writes", 64'(m_lb), 64'd320);
    check("underrun_lb_errs", 64'(m_lb_bad), 64'd0);

    // Reset in the middle of a fetch with reads outstanding.
    mon_reset(19'h01000, 1'b1);
    row = 10'd0; line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (5) step();
    check("midfetch_issues_before_reset", 64'(m_iss), 64'd5);
    rst = 1'b1;
    half();
    check("midfetch_reset_bus_outs", bus_outs(), 64'd0);
    check("midfetch_reset_lb_outs", lb_outs(), 64'd0);
    fin();
    rst = 1'b0;
    mon_reset('0, 1'b0);
    repeat (10) step();
    check("after_reset_lb_writes", 64'(m_lb), 64'd0);
    check("after_reset_rvalid", 64'(m_rv), 64'd0);
    check("after_reset_issues", 64'(m_iss), 64'd0);
    check("after_reset_disp_bank", 64'(disp_bank), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
